// File: rtl/modular_inverse_param.sv
// modular_inverse_param
// Computes out = in^-1 mod modulus for an odd modulus of up to WIDTH bits using
// binary extended Euclid, applying exactly one reduction rule per clock.
// Flow: IDLE -> CHECK -> RUN -> FIN -> IDLE, with a start/ready handshake and a
// one-cycle Done pulse qualified by err.
// Build option: define MODINV_WATCHDOG_EN to add a RUN-cycle watchdog whose
// limit is MAX_ITER, or 2*WIDTH+2 when MAX_ITER is 0.
module modular_inverse_param #(
  parameter int WIDTH    = 256,
  parameter int MAX_ITER = 0
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] modulus,
  output logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             Done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mod_reg,   mod_next;
  logic [WIDTH-1:0] u_reg,     u_next;
  logic [WIDTH-1:0] v_reg,     v_next;
  logic [WIDTH-1:0] x1_reg,    x1_next;
  logic [WIDTH-1:0] x2_reg,    x2_next;
  logic [WIDTH-1:0] out_reg,   out_next;
  logic             err_reg,   err_next;

`ifdef MODINV_WATCHDOG_EN
  localparam int LIMIT = (MAX_ITER == 0) ? (2 * WIDTH + 2) : MAX_ITER;
  localparam int CW    = $clog2(LIMIT + 1);

  logic [CW-1:0] iter_reg, iter_next;
  logic          wd_expired;

  // The current RUN cycle is the last one the watchdog allows.
  assign wd_expired = (iter_reg == CW'(LIMIT - 1));
`endif

  // x/2 mod m for x in [0, m): odd x gets m added first, at WIDTH+1 bits so
  // the carry out of the addition survives the shift.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    sum = {1'b0, x} + (x[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return sum[WIDTH:1];
  endfunction

  // (a - b) mod m for a, b in [0, m). The wrap-around of the WIDTH-bit
  // subtraction is cancelled exactly by adding m.
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    return (a >= b) ? (a - b) : (a - b + m);
  endfunction

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_next = state_reg;
    mod_next   = mod_reg;
    u_next     = u_reg;
    v_next     = v_reg;
    x1_next    = x1_reg;
    x2_next    = x2_reg;
    out_next   = out_reg;
    err_next   = err_reg;
    ready      = 1'b0;
    Done       = 1'b0;
`ifdef MODINV_WATCHDOG_EN
    iter_next  = iter_reg;
`endif

    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          // The operand goes straight into u; the previous result is dropped.
          u_next     = in;
          mod_next   = modulus;
          out_next   = '0;
          err_next   = 1'b0;
          state_next = CHECK;
        end
      end

      CHECK: begin
        if (!mod_reg[0] || (mod_reg < THREE) || (u_reg == '0) || (u_reg >= mod_reg)) begin
          err_next   = 1'b1;
          out_next   = '0;
          state_next = FIN;
        end else begin
          v_next     = mod_reg;
          x1_next    = ONE;
          x2_next    = '0;
          state_next = RUN;
        end
`ifdef MODINV_WATCHDOG_EN
        iter_next = '0;
`endif
      end

      RUN: begin
`ifdef MODINV_WATCHDOG_EN
        iter_next = iter_reg + CW'(1);
`endif
        if (u_reg == ONE) begin
          out_next   = x1_reg;
          state_next = FIN;
        end else if (v_reg == ONE) begin
          out_next   = x2_reg;
          state_next = FIN;
        end else if ((u_reg == '0) || (v_reg == '0)) begin
          // gcd(in, modulus) != 1: no inverse exists.
          err_next   = 1'b1;
          out_next   = '0;
          state_next = FIN;
`ifdef MODINV_WATCHDOG_EN
        end else if (wd_expired) begin
          err_next   = 1'b1;
          out_next   = '0;
          state_next = FIN;
`endif
        end else if (!u_reg[0]) begin
          u_next  = u_reg >> 1;
          x1_next = half_mod(x1_reg, mod_reg);
        end else if (!v_reg[0]) begin
          v_next  = v_reg >> 1;
          x2_next = half_mod(x2_reg, mod_reg);
        end else if (u_reg >= v_reg) begin
          u_next  = u_reg - v_reg;
          x1_next = sub_mod(x1_reg, x2_reg, mod_reg);
        end else begin
          v_next  = v_reg - u_reg;
          x2_next = sub_mod(x2_reg, x1_reg, mod_reg);
        end
      end

      FIN: begin
        Done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      mod_reg   <= '0;
      u_reg     <= '0;
      v_reg     <= '0;
      x1_reg    <= '0;
      x2_reg    <= '0;
      out_reg   <= '0;
      err_reg   <= 1'b0;
`ifdef MODINV_WATCHDOG_EN
      iter_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      mod_reg   <= mod_next;
      u_reg     <= u_next;
      v_reg     <= v_next;
      x1_reg    <= x1_next;
      x2_reg    <= x2_next;
      out_reg   <= out_next;
      err_reg   <= err_next;
`ifdef MODINV_WATCHDOG_EN
      iter_reg  <= iter_next;
`endif
    end
  end

  assign out = out_reg;
  assign err = err_reg;

endmodule

// File: tb/tb_modular_inverse_param.sv
// Testbench for modular_inverse_param (WIDTH=256). Expected results come from a
// division-based extended Euclid model; expected latency comes from counting
// the reduction rules applied to (u, v).
module tb_modular_inverse_param;

  localparam int W = 256;
  localparam logic [W-1:0] SECP_N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  logic         clk     = 1'b0;
  logic         Reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [W-1:0] in_val  = '0;
  logic [W-1:0] mod_val = '0;
  logic         ready;
  logic [W-1:0] out;
  logic         Done;
  logic         err;

  int checks_total  = 0;
  int checks_passed = 0;

  modular_inverse_param #(.WIDTH(W), .MAX_ITER(4 * W + 8)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .start   (start),
    .in      (in_val),
    .modulus (mod_val),
    .ready   (ready),
    .out     (out),
    .Done    (Done),
    .err     (err)
  );

`ifdef MODINV_WATCHDOG_EN
  logic       wd_start = 1'b0;
  logic [7:0] wd_in    = '0;
  logic [7:0] wd_mod   = '0;
  logic       wd_ready;
  logic [7:0] wd_out;
  logic       wd_done;
  logic       wd_err;

  modular_inverse_param #(.WIDTH(8), .MAX_ITER(3)) dut_wd (
    .clk     (clk),
    .Reset_n (Reset_n),
    .start   (wd_start),
    .in      (wd_in),
    .modulus (wd_mod),
    .ready   (wd_ready),
    .out     (wd_out),
    .Done    (wd_done),
    .err     (wd_err)
  );
`endif

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit precheck_err(input logic [W-1:0] a, input logic [W-1:0] m);
    return (m[0] == 1'b0) || (m < W'(3)) || (a == '0) || (a >= m);
  endfunction

  // Inverse by classic division-based extended Euclid at double width.
  function automatic void ref_inverse(input logic [W-1:0] a, input logic [W-1:0] m,
                                      output logic [W-1:0] inv, output logic e);
    logic [2*W-1:0] r0, r1, rt, t0, t1, tn, q, mw;
    inv = '0;
    e   = 1'b1;
    if (precheck_err(a, m)) return;
    mw = {{W{1'b0}}, m};
    r0 = mw;
    r1 = {{W{1'b0}}, a};
    t0 = '0;
    t1 = (2*W)'(1);
    while (r1 != '0) begin
      q  = r0 / r1;
      rt = r0 - q * r1;
      r0 = r1;
      r1 = rt;
      tn = (t0 + mw - ((q * t1) % mw)) % mw;
      t0 = t1;
      t1 = tn;
    end
    if (r0 == (2*W)'(1)) begin
      inv = t0[W-1:0];
      e   = 1'b0;
    end
  endfunction

  // Cycles from the accepting edge to Done: CHECK, then one per rule applied.
  function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] m);
    logic [W-1:0] u, v;
    int n;
    if (precheck_err(a, m)) return 2;
    u = a;
    v = m;
    n = 0;
    while (1) begin
      n++;
      if (u == W'(1) || v == W'(1) || u == '0 || v == '0) break;
      if (!u[0])       u = u >> 1;
      else if (!v[0])  v = v >> 1;
      else if (u >= v) u = u - v;
      else             v = v - u;
    end
    return 2 + n;
  endfunction

  // ---------------- transaction driver ----------------
  // Issues one operation and waits for Done; with noise set it keeps toggling
  // start and scrambling the inputs while the operation is in flight.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] m, input bit noise,
                        output logic [W-1:0] res, output logic e, output int lat,
                        output bit tmo);
    int guard;
    tmo   = 1'b0;
    guard = 0;
    res   = '0;
    e     = 1'bx;
    lat   = 0;
    while (ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (ready !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    in_val  = a;
    mod_val = m;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    in_val  = ~a;
    mod_val = ~m;
    lat     = 1;
    while (Done !== 1'b1 && lat < 4 * W + 50) begin
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        in_val  = rand256();
        mod_val = rand256();
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (Done !== 1'b1) tmo = 1'b1;
    res = out;
    e   = err;
    $display("txn in=%0h mod=%0h out=%0h err=%0b lat=%0d", a, m, res, e, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else checks_passed++;
    checks_total++;
    if (Done !== 1'b0) $display("FAIL reset_done got=%b exp=0", Done); else checks_passed++;
    checks_total++;
    if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else checks_passed++;
    checks_total++;
    if (out !== '0) $display("FAIL reset_out got=%h exp=0", out); else checks_passed++;
    #2 Reset_n = 1'b1;
    @(posedge clk); #1;
    checks_total++;
    if (ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", ready); else checks_passed++;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [8];
    logic [W-1:0] vm [8];
    logic [W-1:0] vo [8];
    logic         ve [8];
    int           vl [8];
    logic [W-1:0] res;
    logic         e;
    int           lat;
    bit           tmo;
    va[0] = 3;   vm[0] = 7;   vo[0] = 5;   ve[0] = 0; vl[0] = 6;
    va[1] = 2;   vm[1] = 13;  vo[1] = 7;   ve[1] = 0; vl[1] = 4;
    va[2] = 250; vm[2] = 251; vo[2] = 250; ve[2] = 0; vl[2] = 14;
    va[3] = 1;   vm[3] = 7;   vo[3] = 1;   ve[3] = 0; vl[3] = 3;
    va[4] = 0;   vm[4] = 7;   vo[4] = 0;   ve[4] = 1; vl[4] = 2;
    va[5] = 5;   vm[5] = 12;  vo[5] = 0;   ve[5] = 1; vl[5] = 2;
    va[6] = 5;   vm[6] = 15;  vo[6] = 0;   ve[6] = 1; vl[6] = 6;
    va[7] = 9;   vm[7] = 7;   vo[7] = 0;   ve[7] = 1; vl[7] = 2;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vm[i], 1'b0, res, e, lat, tmo);
      checks_total++;
      if (tmo !== 1'b0) $display("FAIL vec%0d_timeout got=1 exp=0", i); else checks_passed++;
      checks_total++;
      if (res !== vo[i]) $display("FAIL vec%0d_out got=%0h exp=%0h", i, res, vo[i]); else checks_passed++;
      checks_total++;
      if (e !== ve[i]) $display("FAIL vec%0d_err got=%b exp=%b", i, e, ve[i]); else checks_passed++;
      checks_total++;
      if (lat != vl[i]) $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, vl[i]); else checks_passed++;
    end
  endtask

  task automatic test_random_small();
    logic [W-1:0] a, m, res, exp_inv;
    logic         e, exp_e;
    int           lat;
    bit           tmo;
    for (int i = 0; i < 30; i++) begin
      m = W'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) m[0] = 1'b1;
      a = W'($urandom_range(0, 65535));
      ref_inverse(a, m, exp_inv, exp_e);
      run_op(a, m, 1'b0, res, e, lat, tmo);
      checks_total++;
      if (tmo !== 1'b0) $display("FAIL small%0d_timeout got=1 exp=0", i); else checks_passed++;
      checks_total++;
      if (res !== exp_inv) $display("FAIL small%0d_out got=%0h exp=%0h", i, res, exp_inv); else checks_passed++;
      checks_total++;
      if (e !== exp_e) $display("FAIL small%0d_err got=%b exp=%b", i, e, exp_e); else checks_passed++;
      checks_total++;
      if (lat != ref_latency(a, m)) $display("FAIL small%0d_latency got=%0d exp=%0d", i, lat, ref_latency(a, m));
      else checks_passed++;
    end
  endtask

  task automatic test_secp_random(input int count, input bit noise);
    logic [W-1:0]   a, res, exp_inv;
    logic [2*W-1:0] aw, rw, nw, prod_mod;
    logic           e, exp_e;
    int             lat;
    bit             tmo;
    for (int i = 0; i < count; i++) begin
      a = rand256() % SECP_N;
      if (a == '0) a = W'(1);
      ref_inverse(a, SECP_N, exp_inv, exp_e);
      run_op(a, SECP_N, noise, res, e, lat, tmo);
      aw       = {{W{1'b0}}, a};
      rw       = {{W{1'b0}}, res};
      nw       = {{W{1'b0}}, SECP_N};
      prod_mod = (aw * rw) % nw;
      checks_total++;
      if (tmo !== 1'b0) $display("FAIL secp%0d_n%0d_timeout got=1 exp=0", i, noise); else checks_passed++;
      checks_total++;
      if (res !== exp_inv) $display("FAIL secp%0d_n%0d_out got=%h exp=%h", i, noise, res, exp_inv); else checks_passed++;
      checks_total++;
      if (prod_mod !== (2*W)'(1)) $display("FAIL secp%0d_n%0d_product got=%h exp=1", i, noise, prod_mod); else checks_passed++;
      checks_total++;
      if (e !== 1'b0) $display("FAIL secp%0d_n%0d_err got=%b exp=0", i, noise, e); else checks_passed++;
      checks_total++;
      if (lat != ref_latency(a, SECP_N)) $display("FAIL secp%0d_n%0d_latency got=%0d exp=%0d", i, noise, lat, ref_latency(a, SECP_N));
      else checks_passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res;
    logic         e;
    int           lat;
    bit           tmo;
    in_val  = rand256() % SECP_N;
    mod_val = SECP_N;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 Reset_n = 1'b0;
    #1;
    checks_total++;
    if (ready !== 1'b1) $display("FAIL midreset_ready got=%b exp=1", ready); else checks_passed++;
    checks_total++;
    if (Done !== 1'b0) $display("FAIL midreset_done got=%b exp=0", Done); else checks_passed++;
    checks_total++;
    if (err !== 1'b0) $display("FAIL midreset_err got=%b exp=0", err); else checks_passed++;
    checks_total++;
    if (out !== '0) $display("FAIL midreset_out got=%h exp=0", out); else checks_passed++;
    @(posedge clk); #3 Reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(W'(250), W'(251), 1'b0, res, e, lat, tmo);
    checks_total++;
    if (tmo !== 1'b0) $display("FAIL midreset_fresh_timeout got=1 exp=0"); else checks_passed++;
    checks_total++;
    if (res !== W'(250) || e !== 1'b0) $display("FAIL midreset_fresh_result got=%0h/%b exp=fa/0", res, e);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, res, exp_inv;
    logic         e, exp_e;
    int           lat;
    bit           tmo;
    a = rand256() % SECP_N;
    if (a == '0) a = W'(2);
    ref_inverse(a, SECP_N, exp_inv, exp_e);
    run_op(a, SECP_N, 1'b0, res, e, lat, tmo);
    @(posedge clk); #1;
    checks_total++;
    if (ready !== 1'b1 || Done !== 1'b0) $display("FAIL b2b_idle got=ready%b/done%b exp=ready1/done0", ready, Done);
    else checks_passed++;
    checks_total++;
    if (out !== exp_inv) $display("FAIL b2b_held_out got=%h exp=%h", out, exp_inv); else checks_passed++;
    // start in the first IDLE cycle after Done
    run_op(W'(3), W'(7), 1'b0, res, e, lat, tmo);
    checks_total++;
    if (tmo !== 1'b0 || res !== W'(5) || lat != 6) $display("FAIL b2b_second got=%0h/lat%0d exp=5/lat6", res, lat);
    else checks_passed++;
    // an error result followed immediately by a good one clears err
    @(posedge clk); #1;
    run_op(W'(0), W'(7), 1'b0, res, e, lat, tmo);
    checks_total++;
    if (e !== 1'b1 || res !== '0) $display("FAIL b2b_error got=%0h/%b exp=0/1", res, e); else checks_passed++;
    @(posedge clk); #1;
    run_op(W'(2), W'(13), 1'b0, res, e, lat, tmo);
    checks_total++;
    if (e !== 1'b0 || res !== W'(7) || lat != 4) $display("FAIL b2b_after_error got=%0h/%b/lat%0d exp=7/0/lat4", res, e, lat);
    else checks_passed++;
  endtask

`ifdef MODINV_WATCHDOG_EN
  task automatic test_watchdog();
    int lat;
    while (wd_ready !== 1'b1) begin @(posedge clk); #1; end
    wd_in    = 8'd128;
    wd_mod   = 8'd251;
    wd_start = 1'b1;
    @(posedge clk); #1;
    wd_start = 1'b0;
    lat      = 1;
    while (wd_done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    $display("txn wd in=80 mod=fb out=%0h err=%0b lat=%0d", wd_out, wd_err, lat);
    checks_total++;
    if (wd_done !== 1'b1 || wd_err !== 1'b1 || wd_out !== 8'd0 || lat != 5)
      $display("FAIL watchdog got=done%b/err%b/out%0h/lat%0d exp=done1/err1/out0/lat5", wd_done, wd_err, wd_out, lat);
    else checks_passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_random_small();
    test_secp_random(25, 1'b0);
    test_secp_random(3, 1'b1);
    test_reset_mid();
    test_back_to_back();
`ifdef MODINV_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
